pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
- Owns the PWM period counter and duty register for the PWM signal generator.
- Converts two synchronized push-button levels (up/down) into debounced, saturating duty-cycle steps.
- Holds each new duty value in a shadow register and commits it only at the period boundary, so the output never glitches mid-period.
- Sits between the input synchronizer flip-flop chain and the top-level PWM output pin.

Parameters:
- WIDTH, 8: period counter and duty width; period = 2^WIDTH clocks.
- STEP, 16: duty increment/decrement per accepted press.
- DEB_CYCLES, 1000: consecutive cycles a press must be stable before it is accepted (>=1).
- INIT_DUTY, 128: duty value loaded on reset (must be <= 2^WIDTH-1).
- REPEAT_CYCLES, 50000: auto-repeat interval; used only with BTN_AUTOREPEAT_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- btn_up, input, 1: synchronized up-button level, active-high.
- btn_dn, input, 1: synchronized down-button level, active-high.
- pwm_out, output, 1: registered PWM output.
- period_end, output, 1: high during the cycle where cnt == 2^WIDTH-1.
- duty, output, WIDTH: active (committed) duty.
- duty_shadow, output, WIDTH: pending duty, committed at the next period_end.

Behaviour:
- Reset (asynchronous, while rst=1):
  - cnt=0, pwm_out=0, period_end=0.
  - duty=duty_shadow=INIT_DUTY.
  - FSM=IDLE, deb_cnt=0, rep_cnt=0.
- Period counter:
  - cnt increments by 1 every clk and wraps 2^WIDTH-1 -> 0.
  - period_end is decoded combinationally from cnt.
- PWM output:
  - pwm_out <= (cnt < duty) each edge, evaluated on the pre-increment cnt; one cycle latency.
  - duty=0 gives a constant low output.
  - duty=2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Commit:
  - On each edge where period_end=1, duty <= duty_shadow.
  - The new value drives pwm_out starting from the cnt=0 evaluation of the next period.
  - If a shadow update and a commit happen on the same edge, duty takes the old shadow value and the new value waits one full period.
- Press definitions:
  - sole_up = btn_up & ~btn_dn.
  - sole_dn = btn_dn & ~btn_up.
  - dir = the direction captured on entry to DEBOUNCE.
- FSM, IDLE:
  - sole_up or sole_dn -> DEBOUNCE; capture dir; deb_cnt=1.
  - Both buttons or neither -> stay in IDLE.
- FSM, DEBOUNCE:
  - Sole press in dir still sampled and deb_cnt < DEB_CYCLES -> deb_cnt+1.
  - Sole press in dir sampled and deb_cnt == DEB_CYCLES -> update duty_shadow, go to HOLD, rep_cnt=0.
  - Any other input (release, other button, both) -> IDLE, deb_cnt=0.
  - Net effect: the shadow updates on the (DEB_CYCLES+1)th consecutive edge that samples the sole press.
- FSM, HOLD:
  - Stay while either button is high.
  - Both buttons low -> IDLE.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - up: min(shadow+STEP, 2^WIDTH-1).
  - down: max(shadow-STEP, 0).
  - The value never wraps.
- Reset mid-operation: all state returns to reset values immediately; any pending shadow value is discarded.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In HOLD, while the sole press in dir continues, rep_cnt counts.
  - When rep_cnt reaches REPEAT_CYCLES, apply one more saturating step and reset rep_cnt=0.
  - A release or the other button being pressed stops the repeat.
  - Once the shadow is saturated, further repeats leave it unchanged.
- Undefined:
  - rep_cnt and its logic are absent.
  - Exactly one step is applied per press.

Test Plan:
Parameters: WIDTH=4, STEP=4, DEB_CYCLES=3, INIT_DUTY=8, REPEAT_CYCLES=5.
1. Assert rst, then release it -> duty=8; pwm_out high for 8 of every 16 cycles; period_end pulses once every 16 cycles.
2. Hold btn_up for 10 cycles starting mid-period -> duty_shadow=12 on the 4th sampling edge; duty stays 8 until the next period_end, then becomes 12 (12 high of 16).
3. btn_up high for 2 cycles, low for 1, high for 2 (bounce), then release -> duty_shadow stays 8; FSM returns to IDLE.
4. Four separate clean up presses starting from 8 -> shadow 12, 15, 15, 15 (saturates). Five down presses -> 11, 7, 3, 0, 0.
5. Assert btn_up and btn_dn together for 20 cycles -> no shadow change. Press btn_dn during an up DEBOUNCE -> abort to IDLE, no change.
6. Assert rst during DEBOUNCE with shadow=12 and duty=8 -> all outputs return to reset values immediately; shadow=8 and FSM=IDLE after release. With BTN_AUTOREPEAT_EN, holding btn_up for 20 cycles from 8 -> shadow 12, then 15 after 5 more HOLD cycles, then stays 15.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - PWM period counter with debounced, shadowed duty stepping
// Optional macro BTN_AUTOREPEAT_EN enables auto-repeat while a press is held.
module pwm_duty_sequencer #(
    parameter int WIDTH         = 8,
    parameter int STEP          = 16,
    parameter int DEB_CYCLES    = 1000,
    parameter int INIT_DUTY     = 128,
    parameter int REPEAT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic             pwm_out,
    output logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] duty_shadow
);

    localparam int             DW     = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_W  = DW'(DEB_CYCLES);
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MAX_W  = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt;
    logic [DW-1:0]    deb_cnt, deb_n;
    logic             dir, dir_n;
    logic [WIDTH-1:0] shadow_n;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] step_up, step_dn, stepped;
    logic             sole_up, sole_dn, sole_dir;

    assign period_end = &cnt;
    assign sole_up    = btn_up & ~btn_dn;
    assign sole_dn    = btn_dn & ~btn_up;
    assign sole_dir   = dir ? sole_up : sole_dn;

    // Saturating arithmetic in WIDTH+1 bits so the shadow never wraps.
    assign up_sum  = {1'b0, duty_shadow} + STEP_W;
    assign step_up = (up_sum > MAX_W) ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
    assign step_dn = ({1'b0, duty_shadow} < STEP_W) ? '0 : duty_shadow - STEP_W[WIDTH-1:0];
    assign stepped = dir ? step_up : step_dn;

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_L = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt, rep_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pwm_out     <= 1'b0;
            duty        <= WIDTH'(INIT_DUTY);
            duty_shadow <= WIDTH'(INIT_DUTY);
            state       <= IDLE;
            deb_cnt     <= '0;
            dir         <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            cnt         <= cnt + 1'b1;
            pwm_out     <= (cnt < duty);
            // Commit samples the pre-edge shadow, so a same-edge update waits a period.
            if (period_end)
                duty <= duty_shadow;
            duty_shadow <= shadow_n;
            state       <= state_n;
            deb_cnt     <= deb_n;
            dir         <= dir_n;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt     <= rep_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        deb_n    = deb_cnt;
        dir_n    = dir;
        shadow_n = duty_shadow;
`ifdef BTN_AUTOREPEAT_EN
        rep_n    = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (sole_up | sole_dn) begin
                    state_n = DEBOUNCE;
                    dir_n   = sole_up;
                    deb_n   = DW'(1);
                end
            end
            DEBOUNCE: begin
                if (sole_dir) begin
                    if (deb_cnt == DEB_W) begin
                        shadow_n = stepped;
                        state_n  = HOLD;
                        deb_n    = '0;
`ifdef BTN_AUTOREPEAT_EN
                        rep_n    = '0;
`endif
                    end else begin
                        deb_n = deb_cnt + 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                    deb_n   = '0;
                end
            end
            HOLD: begin
                if (!(btn_up | btn_dn)) begin
                    state_n = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    rep_n   = '0;
                end else if (sole_dir) begin
                    if (rep_cnt == REP_L) begin
                        shadow_n = stepped;
                        rep_n    = '0;
                    end else begin
                        rep_n = rep_cnt + 1'b1;
                    end
                end else begin
                    rep_n = '0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                deb_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - directed, table-driven bench for pwm_duty_sequencer
module tb_pwm_duty_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_up = 1'b0;
    logic         btn_dn = 1'b0;
    logic         pwm_out;
    logic         period_end;
    logic [W-1:0] duty;
    logic [W-1:0] duty_shadow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic up;
        logic dn;
        int   exp_shadow;
    } vec_t;

    vec_t vecs[$];

    pwm_duty_sequencer #(
        .WIDTH(W), .STEP(4), .DEB_CYCLES(3), .INIT_DUTY(8), .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .pwm_out(pwm_out), .period_end(period_end), .duty(duty), .duty_shadow(duty_shadow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic up, input logic dn, input int exp, input int n);
        vec_t v;
        v.up = up;
        v.dn = dn;
        v.exp_shadow = exp;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (vecs[i]) begin
            btn_up = vecs[i].up;
            btn_dn = vecs[i].dn;
            tick();
            check($sformatf("%s[%0d] shadow", name, i), int'(duty_shadow), vecs[i].exp_shadow);
        end
        vecs.delete();
        btn_up = 1'b0;
        btn_dn = 1'b0;
    endtask

    // Leaves the sample at cnt==15; bounded so a stuck counter cannot hang the run.
    task automatic wait_pe(input string name);
        int n = 0;
        while (period_end !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (period_end !== 1'b1) check({name, " period_end timeout"}, 0, 1);
    endtask

    // Commit edge, then sample pwm_out for cnt = 0..15 of one period.
    task automatic measure(input string name, input int exp_high);
        int highs = 0;
        wait_pe(name);
        tick();
        repeat (16) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
        check({name, " high count"}, highs, exp_high);
    endtask

    initial begin
        int pe_count;
        int first_pe;
        int highs;

        // Reset state and free-running period
        tick();
        tick();
        check("rst pwm_out", int'(pwm_out), 0);
        check("rst period_end", int'(period_end), 0);
        check("rst duty", int'(duty), 8);
        check("rst shadow", int'(duty_shadow), 8);
        rst = 1'b0;
        pe_count = 0;
        first_pe = -1;
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (period_end === 1'b1) begin
                pe_count++;
                if (first_pe < 0) first_pe = k;
            end
            if (k <= 16 && pwm_out === 1'b1) highs++;
        end
        check("t1 period_end pulses", pe_count, 2);
        check("t1 first period_end", first_pe, 15);
        check("t1 high count", highs, 8);

        // Up press starting mid-period; commit waits for period_end
        repeat (5) tick();
        btn_up = 1'b1;
        repeat (3) tick();
        check("t2 shadow after 3", int'(duty_shadow), 8);
        tick();
        check("t2 shadow after 4", int'(duty_shadow), 12);
        check("t2 duty held", int'(duty), 8);
        repeat (6) tick();
        check("t2 period_end", int'(period_end), 1);
        check("t2 duty before commit", int'(duty), 8);
        btn_up = 1'b0;
        tick();
        check("t2 duty committed", int'(duty), 12);
        highs = 0;
        repeat (16) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
        check("t2 high count", highs, 12);

        // Bounce then clean up presses to saturation
        do_reset();
        add(1, 0, 8, 2); add(0, 0, 8, 1); add(1, 0, 8, 2); add(0, 0, 8, 2);
        add(1, 0, 8, 3);  add(1, 0, 12, 1); add(0, 0, 12, 1);
        add(1, 0, 12, 3); add(1, 0, 15, 1); add(0, 0, 15, 1);
        add(1, 0, 15, 4); add(0, 0, 15, 1);
        add(1, 0, 15, 4); add(0, 0, 15, 1);
        run_table("tA");
        measure("duty15", 15);

        // Down presses to zero
        add(0, 1, 15, 3); add(0, 1, 11, 1); add(0, 0, 11, 1);
        add(0, 1, 11, 3); add(0, 1, 7, 1);  add(0, 0, 7, 1);
        add(0, 1, 7, 3);  add(0, 1, 3, 1);  add(0, 0, 3, 1);
        add(0, 1, 3, 3);  add(0, 1, 0, 1);  add(0, 0, 0, 1);
        add(0, 1, 0, 4);  add(0, 0, 0, 1);
        run_table("tB");
        measure("duty0", 0);

        // Both buttons held, and down aborting an up debounce
        add(1, 0, 0, 3); add(1, 0, 4, 1); add(0, 0, 4, 1);
        add(1, 1, 4, 20); add(0, 0, 4, 1);
        add(1, 0, 4, 2); add(0, 1, 4, 1); add(1, 0, 4, 3); add(0, 0, 4, 1);
        add(1, 0, 4, 3); add(1, 0, 8, 1); add(0, 0, 8, 1);
        run_table("tC");

        // Shadow update on the commit edge: duty takes the old shadow
        wait_pe("coll");
        tick();
        check("coll duty start", int'(duty), 8);
        repeat (12) tick();
        btn_up = 1'b1;
        repeat (3) tick();
        check("coll period_end", int'(period_end), 1);
        tick();
        check("coll shadow", int'(duty_shadow), 12);
        check("coll duty old", int'(duty), 8);
        btn_up = 1'b0;
        repeat (15) tick();
        check("coll period_end 2", int'(period_end), 1);
        check("coll duty waits", int'(duty), 8);
        tick();
        check("coll duty new", int'(duty), 12);

        // Asynchronous reset during debounce with a pending shadow
        do_reset();
        repeat (2) tick();
        btn_up = 1'b1;
        repeat (4) tick();
        btn_up = 1'b0;
        check("mrst shadow pending", int'(duty_shadow), 12);
        check("mrst duty old", int'(duty), 8);
        tick();
        btn_up = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("mrst duty", int'(duty), 8);
        check("mrst shadow", int'(duty_shadow), 8);
        check("mrst pwm_out", int'(pwm_out), 0);
        check("mrst period_end", int'(period_end), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mrst idle after 3", int'(duty_shadow), 8);
        tick();
        check("mrst idle after 4", int'(duty_shadow), 12);
        btn_up = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
